reg_status_table: RTL and testbench
===================================

REG_STATUS_TABLE -- requirements
Module: reg_status_table

Interface
REQ-001 SHALL have parameter ROB_SIZE_BITS, default 4, which sets the ROB entry index width; tag width is ROB_SIZE_BITS+1 and tag 0 means "no producer".
REQ-002 SHALL have parameter NUM_REGS, default 32, the number of architectural registers (5-bit addresses).
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 alloc_valid  input  1  issue a rename for the instruction being dispatched into the ROB this cycle.
REQ-006 alloc_rd  input  5  destination register of the dispatched instruction.
REQ-007 alloc_roben  input  ROB_SIZE_BITS+1  ROB entry (End_Index) assigned to the dispatched instruction.
REQ-008 rs1_addr, rs2_addr  input  5 each  source register read addresses.
REQ-009 rs1_roben, rs2_roben  output  ROB_SIZE_BITS+1 each  producer tag for each source; 0 means the value is architectural.
REQ-010 rs1_data, rs2_data  output  32 each  architectural register-file value for each source.
REQ-011 commit_wen  input  1  ROB commit write enable.
REQ-012 commit_rd  input  5  ROB commit destination register.
REQ-013 commit_roben  input  ROB_SIZE_BITS+1  ROB head index (Start_Index) of the committing entry.
REQ-014 commit_data  input  32  ROB commit write data.
REQ-015 flush  input  1  ROB FLUSH_Flag; discards all speculative renames.
REQ-016 renamed_count  output  6  number of registers whose tag is currently nonzero.

Function
REQ-017 SHALL hold tag[0..NUM_REGS-1] (ROB_SIZE_BITS+1 bits each) and regfile[0..NUM_REGS-1] (32 bits each).
REQ-018 rs*_roben SHALL be combinational: tag[rs*_addr] as held before the current edge; no bypass from a same-cycle alloc.
REQ-019 rs*_data SHALL be combinational: regfile[rs*_addr], bypassed to commit_data when commit_wen=1, commit_rd=rs*_addr and commit_rd!=0.
REQ-020 Register 0 SHALL always read tag 0 and data 0; writes and allocs to register 0 SHALL be ignored.
REQ-021 Commit: on posedge, when commit_wen=1 and commit_rd!=0, regfile[commit_rd] <= commit_data.
REQ-022 Commit: on the same edge, tag[commit_rd] <= 0 only if tag[commit_rd]==commit_roben; otherwise a younger rename is kept.
REQ-023 Alloc: on posedge, when alloc_valid=1, alloc_rd!=0, alloc_roben!=0 and flush=0, tag[alloc_rd] <= alloc_roben.
REQ-024 When alloc and commit target the same register on the same edge, the alloc SHALL win: the tag becomes alloc_roben and the regfile is still written.
REQ-025 Flush: on posedge with flush=1, all tags SHALL be set to 0 and alloc SHALL be ignored; a commit on the same edge SHALL still write the regfile.
REQ-026 renamed_count SHALL be a registered count of nonzero tags, updated on the same edge as the tag changes: +1 for an alloc to a tag-0 register, -1 for a tag-clearing commit, net 0 for alloc over a nonzero tag, and 0 after a flush.
REQ-027 Wrap-around: tag values SHALL be stored as given, with no arithmetic; alloc_roben values 1..2^ROB_SIZE_BITS are all legal.
REQ-028 There SHALL be no stall or handshake: every input is sampled each posedge, and outputs are valid combinationally after the edge.

Reset
REQ-029 While rst=1 (asynchronous), all tags SHALL be 0, all regfile entries 0, and renamed_count 0; all inputs are ignored.
REQ-030 Reset deasserted mid-sequence SHALL resume from the all-zero state on the next posedge with no residual renames.

Verification
REQ-031 Reset: assert rst, then read r1..r31 -> every roben=0, every data=0, renamed_count=0.
REQ-032 Rename then commit: alloc r5 tag 3; next cycle rs1_addr=5 -> roben=3. Commit r5 tag 3 data 0xDEADBEEF -> the same cycle gives bypass data 0xDEADBEEF; after the edge, roben=0 and count=0.
REQ-033 Stale commit: alloc r7 tag 2, then alloc r7 tag 9, then commit r7 tag 2 data 0x11 -> regfile[7]=0x11, tag stays 9, count=1.
REQ-034 Same-edge collision: r4 holds tag 6; alloc r4 tag 12 while committing r4 tag 6 data 0x55 -> tag=12, regfile[4]=0x55, count unchanged.
REQ-035 Flush: rename r1, r2, r3 (tags 14, 15, 16), then pulse flush with alloc r8 tag 1 and commit r1 tag 14 data 0x7 -> all tags 0, r8 not renamed, regfile[1]=0x7, count=0.
REQ-036 r0: alloc r0 tag 5 and commit r0 data 0xFF -> r0 reads roben 0, data 0, count 0.

Source files
------------

// File: rtl/reg_status_table.sv
// Register rename status table: per-register producer tag plus architectural register file.
// Tags are set on dispatch, cleared by the matching commit and wiped on flush.
module reg_status_table #(
    parameter int ROB_SIZE_BITS = 4,
    parameter int NUM_REGS      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    input  logic [4:0]               alloc_rd,
    input  logic [ROB_SIZE_BITS:0]   alloc_roben,
    input  logic [4:0]               rs1_addr,
    input  logic [4:0]               rs2_addr,
    output logic [ROB_SIZE_BITS:0]   rs1_roben,
    output logic [ROB_SIZE_BITS:0]   rs2_roben,
    output logic [31:0]              rs1_data,
    output logic [31:0]              rs2_data,
    input  logic                     commit_wen,
    input  logic [4:0]               commit_rd,
    input  logic [ROB_SIZE_BITS:0]   commit_roben,
    input  logic [31:0]              commit_data,
    input  logic                     flush,
    output logic [5:0]               renamed_count
);

    localparam int TW = ROB_SIZE_BITS + 1;

    logic [TW-1:0] tag_r      [NUM_REGS];
    logic [31:0]   regfile_r  [NUM_REGS];
    logic [TW-1:0] tag_next_s [NUM_REGS];
    logic [5:0]    count_r;
    logic [5:0]    count_next_s;
    logic          commit_hit_s;
    logic          alloc_hit_s;

    assign commit_hit_s  = commit_wen && (commit_rd != 5'd0);
    assign alloc_hit_s   = alloc_valid && (alloc_rd != 5'd0) &&
                           (alloc_roben != {TW{1'b0}}) && !flush;
    assign renamed_count = count_r;

    // Next tag state; alloc is applied after commit so a same-edge rename wins.
    always_comb begin
        tag_next_s = tag_r;
        if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tag_next_s[i] = {TW{1'b0}};
            end
        end else begin
            if (commit_hit_s && (tag_r[commit_rd] == commit_roben)) begin
                tag_next_s[commit_rd] = {TW{1'b0}};
            end else begin
                tag_next_s[commit_rd] = tag_r[commit_rd];
            end
            if (alloc_hit_s) begin
                tag_next_s[alloc_rd] = alloc_roben;
            end else begin
                tag_next_s[alloc_rd] = tag_next_s[alloc_rd];
            end
        end
    end

    // Population count of the next tag state feeds the registered rename count.
    always_comb begin
        count_next_s = 6'd0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (tag_next_s[i] != {TW{1'b0}}) begin
                count_next_s = count_next_s + 6'd1;
            end else begin
                count_next_s = count_next_s;
            end
        end
    end

    // Tag table and rename count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tag_r[i] <= {TW{1'b0}};
            end
            count_r <= 6'd0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                tag_r[i] <= tag_next_s[i];
            end
            tag_r[0] <= {TW{1'b0}};
            count_r  <= count_next_s;
        end
    end

    // Architectural register file; commits write even on a flush edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regfile_r[i] <= 32'd0;
            end
        end else if (commit_hit_s) begin
            regfile_r[commit_rd] <= commit_data;
        end else begin
            regfile_r[0] <= 32'd0;
        end
    end

    // Source reads: tags reflect pre-edge state, data bypasses the commit in flight.
    always_comb begin
        rs1_roben = (rs1_addr == 5'd0) ? {TW{1'b0}} : tag_r[rs1_addr];
        rs2_roben = (rs2_addr == 5'd0) ? {TW{1'b0}} : tag_r[rs2_addr];
        if (rs1_addr == 5'd0) begin
            rs1_data = 32'd0;
        end else if (commit_hit_s && (commit_rd == rs1_addr)) begin
            rs1_data = commit_data;
        end else begin
            rs1_data = regfile_r[rs1_addr];
        end
        if (rs2_addr == 5'd0) begin
            rs2_data = 32'd0;
        end else if (commit_hit_s && (commit_rd == rs2_addr)) begin
            rs2_data = commit_data;
        end else begin
            rs2_data = regfile_r[rs2_addr];
        end
    end

endmodule

// File: tb/tb_reg_status_table.sv
// Directed self-checking bench for reg_status_table with hand-computed expectations.
module tb_reg_status_table;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic [4:0]  alloc_roben;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rs1_roben;
    logic [4:0]  rs2_roben;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        commit_wen;
    logic [4:0]  commit_rd;
    logic [4:0]  commit_roben;
    logic [31:0] commit_data;
    logic        flush;
    logic [5:0]  renamed_count;

    int cmp_count;
    int err_count;

    reg_status_table #(.ROB_SIZE_BITS(4), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_roben(alloc_roben),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_roben(rs1_roben), .rs2_roben(rs2_roben),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .commit_wen(commit_wen), .commit_rd(commit_rd), .commit_roben(commit_roben),
        .commit_data(commit_data), .flush(flush), .renamed_count(renamed_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_count++;
        if (obs !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_rd = 5'd0; alloc_roben = 5'd0;
        commit_wen = 1'b0; commit_rd = 5'd0; commit_roben = 5'd0;
        commit_data = 32'd0; flush = 1'b0;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic [4:0] tg);
        alloc_valid = 1'b1; alloc_rd = rd; alloc_roben = tg;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [4:0] tg, input logic [31:0] d);
        commit_wen = 1'b1; commit_rd = rd; commit_roben = tg; commit_data = d;
    endtask

    initial begin
        cmp_count = 0;
        err_count = 0;
        idle();
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        rst = 1'b1;
        // Reset state, with junk stimulus that must be ignored
        do_alloc(5'd3, 5'd4);
        do_commit(5'd3, 5'd0, 32'hAAAA_5555);
        tick(); tick();
        idle();
        #1;
        for (int r = 1; r < 32; r++) begin
            rs1_addr = 5'(r);
            rs2_addr = 5'(r);
            #1;
            check_value($sformatf("rst_roben_r%0d", r), 32'(rs1_roben), 32'd0);
            check_value($sformatf("rst_data_r%0d", r), rs2_data, 32'd0);
        end
        check_value("rst_count", 32'(renamed_count), 32'd0);
        rst = 1'b0;
        tick();

        // Rename then commit with bypass
        do_alloc(5'd5, 5'd3);
        rs1_addr = 5'd5;
        #1;
        check_value("no_alloc_bypass", 32'(rs1_roben), 32'd0);
        tick(); idle(); #1;
        check_value("r5_roben", 32'(rs1_roben), 32'd3);
        check_value("r5_count", 32'(renamed_count), 32'd1);
        do_commit(5'd5, 5'd3, 32'hDEAD_BEEF);
        #1;
        check_value("r5_bypass", rs1_data, 32'hDEAD_BEEF);
        tick(); idle(); #1;
        check_value("r5_roben_clr", 32'(rs1_roben), 32'd0);
        check_value("r5_data", rs1_data, 32'hDEAD_BEEF);
        check_value("r5_count_clr", 32'(renamed_count), 32'd0);

        // Stale commit keeps younger rename
        do_alloc(5'd7, 5'd2); tick();
        do_alloc(5'd7, 5'd9); tick(); idle();
        do_commit(5'd7, 5'd2, 32'h0000_0011); tick(); idle();
        rs2_addr = 5'd7; #1;
        check_value("r7_roben", 32'(rs2_roben), 32'd9);
        check_value("r7_data", rs2_data, 32'h0000_0011);
        check_value("r7_count", 32'(renamed_count), 32'd1);

        // Same-edge alloc and commit on one register
        do_alloc(5'd4, 5'd6); tick(); idle(); #1;
        check_value("r4_count", 32'(renamed_count), 32'd2);
        do_alloc(5'd4, 5'd12);
        do_commit(5'd4, 5'd6, 32'h0000_0055);
        tick(); idle();
        rs1_addr = 5'd4; #1;
        check_value("r4_roben", 32'(rs1_roben), 32'd12);
        check_value("r4_data", rs1_data, 32'h0000_0055);
        check_value("r4_count_same", 32'(renamed_count), 32'd2);

        // Flush, including the top tag value 16
        do_alloc(5'd1, 5'd14); tick();
        do_alloc(5'd2, 5'd15); tick();
        do_alloc(5'd3, 5'd16); tick(); idle();
        rs1_addr = 5'd3; #1;
        check_value("r3_roben_16", 32'(rs1_roben), 32'd16);
        check_value("pre_flush_count", 32'(renamed_count), 32'd5);
        flush = 1'b1;
        do_alloc(5'd8, 5'd1);
        do_commit(5'd1, 5'd14, 32'h0000_0007);
        tick(); idle();
        rs1_addr = 5'd1; rs2_addr = 5'd8; #1;
        check_value("flush_r1_roben", 32'(rs1_roben), 32'd0);
        check_value("flush_r1_data", rs1_data, 32'h0000_0007);
        check_value("flush_r8_roben", 32'(rs2_roben), 32'd0);
        rs2_addr = 5'd7; #1;
        check_value("flush_r7_roben", 32'(rs2_roben), 32'd0);
        check_value("flush_count", 32'(renamed_count), 32'd0);

        // Register 0 ignores alloc and commit
        do_alloc(5'd0, 5'd5);
        do_commit(5'd0, 5'd0, 32'h0000_00FF);
        rs1_addr = 5'd0; #1;
        check_value("r0_no_bypass", rs1_data, 32'd0);
        tick(); idle(); #1;
        check_value("r0_roben", 32'(rs1_roben), 32'd0);
        check_value("r0_data", rs1_data, 32'd0);
        check_value("r0_count", 32'(renamed_count), 32'd0);

        // Alloc with tag 0 is ignored
        do_alloc(5'd11, 5'd0); tick(); idle();
        rs1_addr = 5'd11; #1;
        check_value("tag0_alloc_count", 32'(renamed_count), 32'd0);

        // Asynchronous reset mid-sequence
        do_alloc(5'd9, 5'd3); tick(); idle(); #1;
        check_value("pre_rst_count", 32'(renamed_count), 32'd1);
        do_alloc(5'd10, 5'd4);
        rst = 1'b1;
        rs1_addr = 5'd9; rs2_addr = 5'd4; #1;
        check_value("async_rst_count", 32'(renamed_count), 32'd0);
        check_value("async_rst_roben", 32'(rs1_roben), 32'd0);
        check_value("async_rst_data", rs2_data, 32'd0);
        tick();
        rst = 1'b0; idle();
        tick();
        rs1_addr = 5'd10; #1;
        check_value("post_rst_roben", 32'(rs1_roben), 32'd0);
        check_value("post_rst_count", 32'(renamed_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
